// File: rtl/updown_count_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// updown_count_sequencer_pkg
//   Shared encodings for the up/down count sequencer and its counter core.
//   - mode_t  : run mode as presented on the mode input (UP, DOWN, BOUNCE,
//               and the reserved code that a start request rejects)
//   - state_t : sequencer run-control states
// ---------------------------------------------------------------------------
package updown_count_sequencer_pkg;

   typedef enum logic [1:0] {
      MODE_UP     = 2'd0,
      MODE_DOWN   = 2'd1,
      MODE_BOUNCE = 2'd2,
      MODE_RSVD   = 2'd3
   } mode_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_t;

endpackage

// File: rtl/updown_count_sequencer_core.sv
// ---------------------------------------------------------------------------
// updown_counter_core
//   WIDTH-bit binary up/down counter register. Load has priority over count.
//   Ports:
//     clk      in  system clock
//     rst      in  synchronous active-high reset (q -> 0)
//     load     in  load load_val this cycle
//     load_val in  value to load
//     en       in  step the counter this cycle
//     up       in  step direction, 1 = +1, 0 = -1
//     q        out counter value
// ---------------------------------------------------------------------------
module updown_counter_core #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             up,
   output logic [WIDTH-1:0] q
);

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (load) begin
         q <= load_val;
      end else if (en) begin
         q <= up ? q + WIDTH'(1) : q - WIDTH'(1);
      end
   end

endmodule

// File: rtl/updown_count_sequencer.sv
// ---------------------------------------------------------------------------
// updown_count_sequencer
//   Run-control front end for an up/down counter. A start request latches the
//   window [lo,hi], mode and tick divider, then the counter steps once per
//   divided tick, stopping (UP/DOWN) or reversing (BOUNCE) at window edges.
//   Ports:
//     clk, rst         system clock, synchronous active-high reset
//     start            1-cycle run request (ignored while busy or with stop)
//     stop             abort level, sampled each cycle
//     pause            freeze level for counter and divider
//     mode, lo, hi, div run configuration, sampled only on an accepted start
//     q, dir           counter value and current direction (1 = up)
//     busy             high in RUN or PAUSE
//     done, tc, err    1-cycle pulses: run finished, bounce reversal,
//                      start rejected
// ---------------------------------------------------------------------------
module updown_count_sequencer
   import updown_count_sequencer_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int PRESC_W = 23
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic               pause,
   input  logic [1:0]         mode,
   input  logic [WIDTH-1:0]   lo,
   input  logic [WIDTH-1:0]   hi,
   input  logic [PRESC_W-1:0] div,
   output logic [WIDTH-1:0]   q,
   output logic               dir,
   output logic               busy,
   output logic               done,
   output logic               tc,
   output logic               err
);

   state_t               state;
   mode_t                mode_l;
   logic [WIDTH-1:0]     lo_l;
   logic [WIDTH-1:0]     hi_l;
   logic [PRESC_W-1:0]   div_l;
   logic [PRESC_W-1:0]   divider;

   logic                 tick;
   logic                 cfg_ok;
   logic                 at_end;
   logic                 flip;
   logic                 cnt_load;
   logic [WIDTH-1:0]     cnt_val;
   logic                 cnt_en;
   logic                 cnt_up;

   // Window/tick decode and counter control.
   // NOTE: every signal driven here gets a default first so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      tick     = (state == ST_RUN) && (divider == div_l);
      cfg_ok   = (lo <= hi) && (mode_t'(mode) != MODE_RSVD);
      at_end   = ((mode_l == MODE_UP)   && (q == hi_l)) ||
                 ((mode_l == MODE_DOWN) && (q == lo_l));
      flip     = (mode_l == MODE_BOUNCE) &&
                 ((dir && (q == hi_l)) || (!dir && (q == lo_l)));
      cnt_load = 1'b0;
      cnt_val  = lo;
      cnt_en   = 1'b0;
      cnt_up   = dir;

      if ((state == ST_IDLE) && start && !stop && cfg_ok) begin
         cnt_load = 1'b1;
         cnt_val  = (mode_t'(mode) == MODE_DOWN) ? hi : lo;
      end else if (tick && !stop && !at_end) begin
         // A degenerate window (lo==hi) still reverses, but q must not move.
         cnt_en = !(flip && (lo_l == hi_l));
         cnt_up = flip ? !dir : dir;
      end
   end

   updown_counter_core #(.WIDTH(WIDTH)) u_core (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (cnt_val),
      .en       (cnt_en),
      .up       (cnt_up),
      .q        (q)
   );

   // Run-control FSM with registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         mode_l  <= MODE_UP;
         lo_l    <= '0;
         hi_l    <= '0;
         div_l   <= '0;
         divider <= '0;
         dir     <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
         tc      <= 1'b0;
         err     <= 1'b0;
      end else begin
         done <= 1'b0;
         tc   <= 1'b0;
         err  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start && !stop) begin
                  if (!cfg_ok) begin
                     err <= 1'b1;
                  end else begin
                     state   <= ST_RUN;
                     busy    <= 1'b1;
                     mode_l  <= mode_t'(mode);
                     lo_l    <= lo;
                     hi_l    <= hi;
                     div_l   <= div;
                     divider <= '0;
                     dir     <= (mode_t'(mode) != MODE_DOWN);
                  end
               end
            end
            ST_RUN: begin
               if (stop) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else begin
                  divider <= tick ? '0 : divider + PRESC_W'(1);
                  if (tick && at_end) begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     if (tick && flip) begin
                        dir <= !dir;
                        tc  <= 1'b1;
                     end
                     if (pause) state <= ST_PAUSE;
                  end
               end
            end
            ST_PAUSE: begin
               if (stop) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else if (!pause) begin
                  state <= ST_RUN;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_updown_count_sequencer.sv
// ---------------------------------------------------------------------------
// tb_updown_count_sequencer
//   Directed vector table, hand-written multi-cycle sequences and a random
//   phase, all compared against a behavioural model of the run rules.
// ---------------------------------------------------------------------------
module tb_updown_count_sequencer;

   localparam int W = 4;
   localparam int P = 23;

   logic         clk = 1'b0;
   logic         rst, start, stop, pause;
   logic [1:0]   mode;
   logic [W-1:0] lo, hi;
   logic [P-1:0] div;
   logic [W-1:0] q;
   logic         dir, busy, done, tc, err;

   int errors = 0;
   int checks = 0;
   string tag;

   updown_count_sequencer #(.WIDTH(W), .PRESC_W(P)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
      .mode(mode), .lo(lo), .hi(hi), .div(div),
      .q(q), .dir(dir), .busy(busy), .done(done), .tc(tc), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Behavioural model: counts cycles since the last tick, moves an integer
   // value inside the window, and records the pulses each rule produces.
   int m_q, m_lo, m_hi, m_mode, m_div, m_phase;
   bit m_dir, m_busy, m_paused, m_done, m_tc, m_err;

   task automatic model_step();
      m_done = 0; m_tc = 0; m_err = 0;
      if (rst) begin
         m_q = 0; m_dir = 1; m_busy = 0; m_paused = 0;
         m_lo = 0; m_hi = 0; m_mode = 0; m_div = 0; m_phase = 0;
      end else if (!m_busy) begin
         if (start && !stop) begin
            if (lo > hi || mode == 3) begin
               m_err = 1;
            end else begin
               m_busy = 1; m_paused = 0; m_phase = 0;
               m_lo = lo; m_hi = hi; m_mode = mode; m_div = int'(div);
               if (mode == 1) begin m_q = m_hi; m_dir = 0; end
               else           begin m_q = m_lo; m_dir = 1; end
            end
         end
      end else if (stop) begin
         m_busy = 0; m_paused = 0;
      end else if (m_paused) begin
         if (!pause) m_paused = 0;
      end else begin
         if (m_phase == m_div) begin
            m_phase = 0;
            if (m_mode == 0) begin
               if (m_q == m_hi) begin m_done = 1; m_busy = 0; end
               else m_q = m_q + 1;
            end else if (m_mode == 1) begin
               if (m_q == m_lo) begin m_done = 1; m_busy = 0; end
               else m_q = m_q - 1;
            end else begin
               if ((m_dir && m_q == m_hi) || (!m_dir && m_q == m_lo)) begin
                  m_dir = !m_dir; m_tc = 1;
               end
               if (m_lo != m_hi) m_q = m_dir ? m_q + 1 : m_q - 1;
            end
         end else begin
            m_phase = m_phase + 1;
         end
         if (m_busy && pause) m_paused = 1;
      end
   endtask

   task automatic cycle(input bit r, input bit s, input bit sp, input bit pz,
                        input int md, input int l, input int h, input int d);
      rst = r; start = s; stop = sp; pause = pz;
      mode = 2'(md); lo = W'(l); hi = W'(h); div = P'(d);
      @(posedge clk);
      model_step();
      #1;
      check({tag, " mdl q"},    32'(q),    32'(m_q));
      check({tag, " mdl dir"},  32'(dir),  32'(m_dir));
      check({tag, " mdl busy"}, 32'(busy), 32'(m_busy));
      check({tag, " mdl done"}, 32'(done), 32'(m_done));
      check({tag, " mdl tc"},   32'(tc),   32'(m_tc));
      check({tag, " mdl err"},  32'(err),  32'(m_err));
   endtask

   task automatic idle(input bit pz);
      cycle(0, 0, 0, pz, 0, 0, 0, 0);
   endtask

   typedef struct {
      bit start, stop;
      int mode, lo, hi, div;
      int q;
      bit dir, busy, done, tc, err;
   } vec_t;

   initial begin
      vec_t vt[14];
      int   pq[12];
      int   bq[8];
      bit   btc[8];
      int   done_cnt;
      bit   pz;

      // Reset state.
      tag = "reset";
      cycle(1, 0, 0, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0, 0, 0);
      check("reset q", 32'(q), 0);
      check("reset dir", 32'(dir), 1);
      check("reset busy", 32'(busy), 0);
      check("reset pulses", {29'd0, done, tc, err}, 0);

      // Directed vectors: UP 3..6, rejected starts, start+stop, UP 14..15.
      vt[0]  = '{1,0, 0, 3, 6,0,  3,1,1,0,0,0};
      vt[1]  = '{0,0, 0, 0, 0,0,  4,1,1,0,0,0};
      vt[2]  = '{0,0, 0, 0, 0,0,  5,1,1,0,0,0};
      vt[3]  = '{0,0, 0, 0, 0,0,  6,1,1,0,0,0};
      vt[4]  = '{0,0, 0, 0, 0,0,  6,1,0,1,0,0};
      vt[5]  = '{0,0, 0, 0, 0,0,  6,1,0,0,0,0};
      vt[6]  = '{1,0, 0, 9, 4,0,  6,1,0,0,0,1};
      vt[7]  = '{0,0, 0, 0, 0,0,  6,1,0,0,0,0};
      vt[8]  = '{1,0, 3, 1, 2,0,  6,1,0,0,0,1};
      vt[9]  = '{1,1, 0, 1, 2,0,  6,1,0,0,0,0};
      vt[10] = '{1,0, 0,14,15,0, 14,1,1,0,0,0};
      vt[11] = '{0,0, 0, 0, 0,0, 15,1,1,0,0,0};
      vt[12] = '{0,0, 0, 0, 0,0, 15,1,0,1,0,0};
      vt[13] = '{0,0, 0, 0, 0,0, 15,1,0,0,0,0};
      for (int i = 0; i < 14; i++) begin
         tag = $sformatf("vec%0d", i);
         cycle(0, vt[i].start, vt[i].stop, 0, vt[i].mode, vt[i].lo, vt[i].hi, vt[i].div);
         check({tag, " q"},    32'(q),    32'(vt[i].q));
         check({tag, " dir"},  32'(dir),  32'(vt[i].dir));
         check({tag, " busy"}, 32'(busy), 32'(vt[i].busy));
         check({tag, " done"}, 32'(done), 32'(vt[i].done));
         check({tag, " tc"},   32'(tc),   32'(vt[i].tc));
         check({tag, " err"},  32'(err),  32'(vt[i].err));
      end

      // DOWN 5..2 with div=2: one step every 3 cycles, single done pulse.
      tag = "down";
      done_cnt = 0;
      cycle(0, 1, 0, 0, 1, 2, 5, 2);
      for (int k = 1; k <= 15; k++) begin
         if (k > 1) idle(0);
         check($sformatf("down q k%0d", k), 32'(q), 32'((k <= 12) ? 5 - (k - 1) / 3 : 2));
         check($sformatf("down busy k%0d", k), 32'(busy), 32'(k <= 12));
         check($sformatf("down dir k%0d", k), 32'(dir), 0);
         if (done) done_cnt++;
         if (k == 13) check("down done at end", 32'(done), 1);
      end
      check("down done count", 32'(done_cnt), 1);

      // BOUNCE 0..2, then stop holds q.
      tag = "bounce";
      bq  = '{0, 1, 2, 1, 0, 1, 2, 1};
      btc = '{0, 0, 0, 1, 0, 1, 0, 1};
      cycle(0, 1, 0, 0, 2, 0, 2, 0);
      for (int k = 1; k <= 8; k++) begin
         if (k > 1) idle(0);
         check($sformatf("bounce q k%0d", k), 32'(q), 32'(bq[k-1]));
         check($sformatf("bounce tc k%0d", k), 32'(tc), 32'(btc[k-1]));
      end
      cycle(0, 0, 1, 0, 0, 0, 0, 0);
      check("bounce stop q", 32'(q), 1);
      check("bounce stop busy", 32'(busy), 0);
      check("bounce stop dir", 32'(dir), 0);

      // Pause for 5 cycles mid-run with div=1; a start during pause is ignored.
      tag = "pause";
      pq = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 2, 2, 3};
      cycle(0, 1, 0, 0, 0, 0, 15, 1);
      for (int k = 2; k <= 12; k++) begin
         pz = (k >= 4 && k <= 8);
         if (k == 6) cycle(0, 1, 0, pz, 1, 5, 9, 0);
         else        idle(pz);
      end
      // The loop above already compared every cycle to the model; recheck the
      // final phase position against the hand-derived timeline.
      check("pause q k12", 32'(q), 32'(pq[11]));
      check("pause busy k12", 32'(busy), 1);
      check("pause dir k12", 32'(dir), 1);
      cycle(0, 0, 1, 0, 0, 0, 0, 0);
      check("pause stop busy", 32'(busy), 0);

      // Reset in the middle of a BOUNCE run, then a clean UP run.
      tag = "rstmid";
      cycle(0, 1, 0, 0, 2, 3, 7, 0);
      for (int k = 0; k < 6; k++) idle(0);
      cycle(1, 0, 0, 0, 0, 0, 0, 0);
      check("rstmid q", 32'(q), 0);
      check("rstmid dir", 32'(dir), 1);
      check("rstmid status", {28'd0, busy, done, tc, err}, 0);
      cycle(0, 1, 0, 0, 0, 1, 2, 0);
      check("rstmid run q1", 32'(q), 1);
      idle(0);
      check("rstmid run q2", 32'(q), 2);
      idle(0);
      check("rstmid run done", 32'(done), 1);
      check("rstmid run busy", 32'(busy), 0);

      // Random stimulus against the model.
      tag = "rand";
      pz = 0;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 11) == 0) pz = !pz;
         cycle($urandom_range(0, 199) == 0, $urandom_range(0, 9) == 0,
               $urandom_range(0, 49) == 0, pz,
               int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
